// File: rtl/alu_datapath.sv
// ALU datapath: operand select, priority-encoded ALU and registered accumulator.
// The instruction strobes are nominally one-hot. When several are raised together,
// the fixed priority chain decides which result reaches aluOut.
module alu_datapath #(
  parameter int unsigned INPUT_DATA_WIDTH  = 4,
  parameter int unsigned OUTPUT_DATA_WIDTH = 8
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [INPUT_DATA_WIDTH-1:0]  Ain,
  input  logic [INPUT_DATA_WIDTH-1:0]  Bin,
  input  logic [OUTPUT_DATA_WIDTH-1:0] shiftIn,
  input  logic                         SF,
  input  logic                         ADD,
  input  logic                         SUB,
  input  logic                         AND,
  input  logic                         OR,
  input  logic                         XOR,
  input  logic                         INV,
  input  logic                         CLR,
  input  logic                         SNZA,
  input  logic                         SNZS,
  output logic [OUTPUT_DATA_WIDTH-1:0] aluOut,
  output logic                         overflow,
  output logic [OUTPUT_DATA_WIDTH-1:0] ACCout
);

  localparam int unsigned OW = OUTPUT_DATA_WIDTH;

  logic [OW-1:0] r_acc;
  logic [OW-1:0] w_ain_ext;
  logic [OW-1:0] w_bin_ext;
  logic [OW-1:0] w_in1;
  logic [OW-1:0] w_in2;
  logic [OW:0]   w_sum;
  logic [OW:0]   w_diff;
  logic          w_add_eff;
  logic          w_acc_en;

  assign w_ain_ext = OW'(Ain);
  assign w_bin_ext = OW'(Bin);

  // Conditional skips become adds against the accumulator when the shift flag is set
  assign w_add_eff = ADD | (SNZA & SF) | (SNZS & SF);
  assign w_acc_en  = AND | OR | XOR | INV | w_add_eff | SUB | CLR;

  // Operand select: SNZA wins over SNZS, otherwise the plain A/B registers
  always_comb begin
    w_in1 = w_ain_ext;
    w_in2 = w_bin_ext;
    if (SNZA) begin
      w_in1 = r_acc;
      w_in2 = w_ain_ext;
    end else if (SNZS) begin
      w_in1 = r_acc;
      w_in2 = shiftIn;
    end
  end

  // One extra bit carries the carry-out / unsigned borrow
  assign w_sum  = {1'b0, w_in1} + {1'b0, w_in2};
  assign w_diff = {1'b0, w_in1} - {1'b0, w_in2};

  // Priority-encoded ALU result and flag
  always_comb begin
    aluOut   = '0;
    overflow = 1'b0;
    if (CLR) begin
      aluOut   = '0;
      overflow = 1'b0;
    end else if (w_add_eff) begin
      aluOut   = w_sum[OW-1:0];
      overflow = w_sum[OW];
    end else if (SUB) begin
      aluOut   = w_diff[OW-1:0];
      overflow = w_diff[OW];
    end else if (AND) begin
      aluOut = w_in1 & w_in2;
    end else if (OR) begin
      aluOut = w_in1 | w_in2;
    end else if (XOR) begin
      aluOut = w_in1 ^ w_in2;
    end else if (INV) begin
      aluOut = ~w_in1;
    end
  end

  // Accumulator: reset or CLR clears, any active operation loads, otherwise hold
  always_ff @(posedge clk) begin
    if (reset || CLR) begin
      r_acc <= '0;
    end else if (w_acc_en) begin
      r_acc <= aluOut;
    end
  end

  assign ACCout = r_acc;

endmodule

// File: tb/tb_alu_datapath.sv
// Self-checking bench for alu_datapath: directed vector table, then random ops vs a model.
module tb_alu_datapath;

  localparam int IW = 4;
  localparam int OW = 8;

  logic          clk = 1'b0;
  logic          reset;
  logic [IW-1:0] Ain, Bin;
  logic [OW-1:0] shiftIn;
  logic          SF;
  logic          op_add, op_sub, op_and, op_or, op_xor, op_inv, op_clr, op_snza, op_snzs;
  logic [OW-1:0] aluOut;
  logic          overflow;
  logic [OW-1:0] ACCout;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  alu_datapath #(
    .INPUT_DATA_WIDTH (IW),
    .OUTPUT_DATA_WIDTH(OW)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .Ain     (Ain),
    .Bin     (Bin),
    .shiftIn (shiftIn),
    .SF      (SF),
    .ADD     (op_add),
    .SUB     (op_sub),
    .AND     (op_and),
    .OR      (op_or),
    .XOR     (op_xor),
    .INV     (op_inv),
    .CLR     (op_clr),
    .SNZA    (op_snza),
    .SNZS    (op_snzs),
    .aluOut  (aluOut),
    .overflow(overflow),
    .ACCout  (ACCout)
  );

  // ops bit order: {ADD, SUB, AND, OR, XOR, INV, CLR, SNZA, SNZS}
  localparam logic [8:0] K_ADD  = 9'b100000000;
  localparam logic [8:0] K_SUB  = 9'b010000000;
  localparam logic [8:0] K_AND  = 9'b001000000;
  localparam logic [8:0] K_OR   = 9'b000100000;
  localparam logic [8:0] K_XOR  = 9'b000010000;
  localparam logic [8:0] K_INV  = 9'b000001000;
  localparam logic [8:0] K_CLR  = 9'b000000100;
  localparam logic [8:0] K_SNZA = 9'b000000010;
  localparam logic [8:0] K_SNZS = 9'b000000001;

  typedef struct {
    string         name;
    logic          rst;
    logic [8:0]    ops;
    logic [IW-1:0] a;
    logic [IW-1:0] b;
    logic [OW-1:0] sh;
    logic          sf;
    logic [OW-1:0] exp_alu;
    logic          exp_ov;
    logic [OW-1:0] exp_acc;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(string n, logic r, logic [8:0] o, logic [IW-1:0] a,
                              logic [IW-1:0] b, logic [OW-1:0] sh, logic sf,
                              logic [OW-1:0] ea, logic eo, logic [OW-1:0] ec);
    vec_t v;
    v.name = n; v.rst = r; v.ops = o; v.a = a; v.b = b; v.sh = sh; v.sf = sf;
    v.exp_alu = ea; v.exp_ov = eo; v.exp_acc = ec;
    return v;
  endfunction

  task automatic drive(logic r, logic [8:0] o, logic [IW-1:0] a, logic [IW-1:0] b,
                       logic [OW-1:0] sh, logic sf);
    reset = r; Ain = a; Bin = b; shiftIn = sh; SF = sf;
    {op_add, op_sub, op_and, op_or, op_xor, op_inv, op_clr, op_snza, op_snzs} = o;
  endtask

  task automatic check(string n, logic [OW-1:0] act, logic [OW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", n, act, exp);
    end
  endtask

  // Reference model in plain integer arithmetic
  int unsigned model_acc;

  task automatic model(logic r, logic [8:0] o, int unsigned a, int unsigned b,
                       int unsigned sh, logic sf,
                       output int unsigned alu, output int unsigned ov);
    bit add, sub, an, orr, xr, inv, clr, snza, snzs, add_eff;
    int unsigned x, y, m;
    {add, sub, an, orr, xr, inv, clr, snza, snzs} = o;
    m = 1 << OW;
    add_eff = add || (sf && (snza || snzs));
    x = (snza || snzs) ? model_acc : a;
    y = snza ? a : (snzs ? sh : b);
    alu = 0; ov = 0;
    if (clr) begin
      alu = 0;
    end else if (add_eff) begin
      alu = (x + y) % m; ov = (x + y >= m) ? 1 : 0;
    end else if (sub) begin
      alu = (x + m - y) % m; ov = (x < y) ? 1 : 0;
    end else if (an) alu = x & y;
    else if (orr)   alu = x | y;
    else if (xr)    alu = x ^ y;
    else if (inv)   alu = (m - 1) - x;
  endtask

  task automatic model_step(logic r, logic [8:0] o, int unsigned alu);
    bit add_eff, en;
    add_eff = o[8] || (SF && (o[1] || o[0]));
    en = add_eff || (o[7:2] != 0);
    if (r || o[2]) model_acc = 0;
    else if (en)   model_acc = alu;
  endtask

  initial begin
    int unsigned ea, eo;
    logic [8:0] o;
    logic r;

    drive(1'b0, '0, '0, '0, '0, 1'b0);

    // Directed table; accumulator carries from one row to the next
    vecs.push_back(mk("reset_add",  1, K_ADD,  4'h9, 4'h7, 8'h00, 0, 8'h10, 0, 8'h00));
    vecs.push_back(mk("add",        0, K_ADD,  4'h9, 4'h7, 8'h00, 0, 8'h10, 0, 8'h10));
    vecs.push_back(mk("sub_borrow", 0, K_SUB,  4'h3, 4'h5, 8'h00, 0, 8'hFE, 1, 8'hFE));
    vecs.push_back(mk("and",        0, K_AND,  4'hA, 4'h6, 8'h00, 0, 8'h02, 0, 8'h02));
    vecs.push_back(mk("or",         0, K_OR,   4'hA, 4'h6, 8'h00, 0, 8'h0E, 0, 8'h0E));
    vecs.push_back(mk("xor",        0, K_XOR,  4'hA, 4'h6, 8'h00, 0, 8'h0C, 0, 8'h0C));
    vecs.push_back(mk("inv",        0, K_INV,  4'hA, 4'h6, 8'h00, 0, 8'hF5, 0, 8'hF5));
    vecs.push_back(mk("inv_f",      0, K_INV,  4'hF, 4'h0, 8'h00, 0, 8'hF0, 0, 8'hF0));
    vecs.push_back(mk("snzs_sf0",   0, K_SNZS, 4'h0, 4'h0, 8'h20, 0, 8'h00, 0, 8'hF0));
    vecs.push_back(mk("snzs_sf1",   0, K_SNZS, 4'h0, 4'h0, 8'h20, 1, 8'h10, 1, 8'h10));
    vecs.push_back(mk("snza_sf1",   0, K_SNZA, 4'h4, 4'h0, 8'h00, 1, 8'h14, 0, 8'h14));
    vecs.push_back(mk("snza_sf0",   0, K_SNZA, 4'h4, 4'h0, 8'h00, 0, 8'h00, 0, 8'h14));
    vecs.push_back(mk("snza_snzs",  0, K_SNZA | K_SNZS, 4'h1, 4'h0, 8'h80, 1, 8'h15, 0, 8'h15));
    vecs.push_back(mk("clr",        0, K_CLR | K_ADD, 4'h9, 4'h7, 8'h00, 0, 8'h00, 0, 8'h00));
    vecs.push_back(mk("add2",       0, K_ADD,  4'h1, 4'h2, 8'h00, 0, 8'h03, 0, 8'h03));
    vecs.push_back(mk("sub_and",    0, K_SUB | K_AND, 4'h7, 4'h2, 8'h00, 0, 8'h05, 0, 8'h05));
    vecs.push_back(mk("or_xor",     0, K_OR | K_XOR | K_INV, 4'h5, 4'h3, 8'h00, 0, 8'h07, 0,
                      8'h07));
    vecs.push_back(mk("reset_add2", 1, K_ADD,  4'h9, 4'h7, 8'h00, 0, 8'h10, 0, 8'h00));

    @(posedge clk); #1;
    foreach (vecs[i]) begin
      drive(vecs[i].rst, vecs[i].ops, vecs[i].a, vecs[i].b, vecs[i].sh, vecs[i].sf);
      #2;
      check({vecs[i].name, ".alu"}, aluOut, vecs[i].exp_alu);
      check({vecs[i].name, ".ov"}, 8'(overflow), 8'(vecs[i].exp_ov));
      @(posedge clk); #1;
      check({vecs[i].name, ".acc"}, ACCout, vecs[i].exp_acc);
    end

    // Load a value, then idle several cycles: accumulator must hold
    drive(0, K_ADD, 4'hC, 4'h5, 8'h00, 0);
    @(posedge clk); #1;
    drive(0, 9'h000, 4'hF, 4'hF, 8'hFF, 1);
    #2;
    check("idle.alu", aluOut, 8'h00);
    repeat (3) @(posedge clk);
    #1;
    check("idle.hold", ACCout, 8'h11);

    // Random ops against the model
    model_acc = 32'h11;
    for (int n = 0; n < 400; n++) begin
      if ($urandom_range(0, 3) == 0) o = 9'($urandom);
      else o = 9'(1) << $urandom_range(0, 8);
      r = ($urandom_range(0, 31) == 0);
      drive(r, o, IW'($urandom), IW'($urandom), OW'($urandom), 1'($urandom));
      model(r, o, Ain, Bin, shiftIn, SF, ea, eo);
      #2;
      check("rnd.alu", aluOut, OW'(ea));
      check("rnd.ov", 8'(overflow), 8'(eo));
      model_step(r, o, ea);
      @(posedge clk); #1;
      check("rnd.acc", ACCout, OW'(model_acc));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/alu_datapath.md
ALU_DATAPATH -- requirements
Module: alu_datapath

Interface
REQ-001 Parameter INPUT_DATA_WIDTH, default 4, width of operand inputs Ain/Bin.
REQ-002 Parameter OUTPUT_DATA_WIDTH, default 8, width of shift operand, ALU result and accumulator.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 reset  input  1  synchronous, active-high; clears accumulator.
REQ-005 Ain  input  INPUT_DATA_WIDTH  register A operand.
REQ-006 Bin  input  INPUT_DATA_WIDTH  register B operand.
REQ-007 shiftIn  input  OUTPUT_DATA_WIDTH  shift-register contents.
REQ-008 SF  input  1  shift flag (condition for SNZA/SNZS).
REQ-009 ADD, SUB, AND, OR, XOR, INV, CLR, SNZA, SNZS  input  1 each  decoded instruction strobes, nominally one-hot.
REQ-010 aluOut  output  OUTPUT_DATA_WIDTH  combinational ALU result.
REQ-011 overflow  output  1  combinational carry/borrow of current operation.
REQ-012 ACCout  output  OUTPUT_DATA_WIDTH  registered accumulator value.

Function
REQ-013 Effective add: addEff = ADD | (SNZA & SF) | (SNZS & SF).
REQ-014 Operand select, default: in1 = zero-extended Ain, in2 = zero-extended Bin.
REQ-015 SNZA asserted: in1 = ACCout, in2 = zero-extended Ain.
REQ-016 SNZS asserted: in1 = ACCout, in2 = shiftIn; SNZA takes precedence if both asserted.
REQ-017 Operation priority: CLR > addEff > SUB > AND > OR > XOR > INV; none active -> aluOut = 0.
REQ-018 CLR: aluOut = 0, overflow = 0.
REQ-019 addEff: aluOut = (in1 + in2) mod 2^OUTPUT_DATA_WIDTH; overflow = carry-out bit.
REQ-020 SUB: aluOut = (in1 - in2) mod 2^OUTPUT_DATA_WIDTH; overflow = 1 iff in1 < in2 (unsigned borrow).
REQ-021 AND/OR/XOR: bitwise on in1, in2 (full OUTPUT_DATA_WIDTH); overflow = 0.
REQ-022 INV: aluOut = bitwise NOT of in1 (full width, upper bits become 1); overflow = 0.
REQ-023 Accumulator enable = AND | OR | XOR | INV | addEff | SUB | CLR.
REQ-024 Rising edge: if reset or CLR, ACCout <= 0; else if enable, ACCout <= aluOut; else hold.
REQ-025 SNZA/SNZS with SF = 0: no enable, ACCout holds, aluOut = 0 (no operation active).
REQ-026 aluOut and overflow shall be purely combinational; single-cycle latency from strobe to ACCout.
REQ-027 Multiple strobes simultaneously: result follows REQ-017 priority; ACC still loads per REQ-023/024.

Reset
REQ-028 reset synchronous: ACCout = 0 after first rising edge with reset = 1, regardless of strobes.
REQ-029 reset has no effect on combinational outputs except through ACCout.
REQ-030 ACCout undefined before first reset edge; bench shall apply reset first.

Verification
REQ-031 Ain=4'h9, Bin=4'h7, ADD=1, one edge -> aluOut=8'h10, overflow=0, ACCout=8'h10.
REQ-032 Ain=4'h3, Bin=4'h5, SUB=1 -> aluOut=8'hFE, overflow=1; ACCout=8'hFE after edge.
REQ-033 Ain=4'hA, Bin=4'h6: AND -> 8'h02, OR -> 8'h0E, XOR -> 8'h0C, INV -> 8'hF5; overflow=0 each.
REQ-034 ACCout=8'hF0, shiftIn=8'h20, SNZS=1, SF=1 -> aluOut=8'h10, overflow=1, ACCout=8'h10; same with SF=0 -> ACCout holds 8'hF0.
REQ-035 ACCout=8'h10, Ain=4'h4, SNZA=1, SF=1 -> ACCout=8'h14 after edge.
REQ-036 ACCout nonzero, CLR=1 (or reset=1 with ADD=1) -> ACCout=8'h00 after next edge.
